// File: rtl/tdl_pkg.sv
// Shared defaults and helpers for the multi-channel tapped delay line.
package tdl_pkg;

    localparam int TDL_WIDTH = 16;
    localparam int TDL_DEPTH = 32;
    localparam int TDL_NCH   = 4;

    // A single channel still needs a one-bit index port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdl_channel.sv
// One channel of the delay line: DEPTH x WIDTH shift register plus a saturating fill counter.
module tdl_channel
    import tdl_pkg::*;
#(
    parameter int WIDTH = TDL_WIDTH,
    parameter int DEPTH = TDL_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clr,
    input  logic                          shift_en,
    input  logic [WIDTH-1:0]              din,
    output logic [DEPTH-1:0][WIDTH-1:0]   line_o,
    output logic [LEN_W-1:0]              fill_o
);

    typedef logic [WIDTH-1:0]            sample_t;
    typedef logic [DEPTH-1:0][WIDTH-1:0] tap_vec_t;

    tap_vec_t          line_q, line_d;
    logic [LEN_W-1:0]  fill_q, fill_d;
    sample_t           newSample;

    assign newSample = din;

    always_comb begin
        line_d = line_q;
        fill_d = fill_q;
        if (clr) begin
            line_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            line_d[0] = newSample;
            for (int i = 1; i < DEPTH; i++) begin
                line_d[i] = line_q[i-1];
            end
            if (fill_q != LEN_W'(DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_q <= '0;
            fill_q <= '0;
        end else begin
            line_q <= line_d;
            fill_q <= fill_d;
        end
    end

    assign line_o = line_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/mc_tapped_delay_line.sv
// Multi-channel tapped delay line: per-channel shift lines, channel mux, length mask and a
// one-deep valid/ready snapshot register.
module mc_tapped_delay_line
    import tdl_pkg::*;
#(
    parameter  int WIDTH = TDL_WIDTH,
    parameter  int DEPTH = TDL_DEPTH,
    parameter  int NCH   = TDL_NCH,
    localparam int CH_W  = clog2_min1(NCH),
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CH_W-1:0]               in_ch,
    input  logic [WIDTH-1:0]              din,
    input  logic [LEN_W-1:0]              active_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_W-1:0]               out_ch,
    output logic [DEPTH-1:0][WIDTH-1:0]   taps,
    output logic                          out_primed,
    output logic                          err_ch
);

    typedef logic [DEPTH-1:0][WIDTH-1:0] tap_vec_t;

    tap_vec_t          chLine [NCH];
    logic [LEN_W-1:0]  chFill [NCH];
    logic [NCH-1:0]    shiftEn;

    logic              accept;
    logic              chInRange;
    logic              popOut;
    tap_vec_t          selLine;
    tap_vec_t          nextTaps;
    logic [LEN_W-1:0]  selFill;
    logic [LEN_W-1:0]  postFill;
    logic [LEN_W-1:0]  effLen;

    logic              outValid_q;
    logic [CH_W-1:0]   outCh_q;
    tap_vec_t          taps_q;
    logic              outPrimed_q;
    logic              errCh_q;

    assign in_ready  = !flush && (!outValid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign popOut    = outValid_q && out_ready;
    assign chInRange = ({1'b0, in_ch} < (CH_W + 1)'(NCH));

    // Flush needs no separate gating of shiftEn: in_ready is already low during flush.
    for (genvar c = 0; c < NCH; c++) begin : gCh
        assign shiftEn[c] = accept && chInRange && (in_ch == CH_W'(c));

        tdl_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .LEN_W (LEN_W)
        ) uChannel (
            .clk      (clk),
            .rstn     (rstn),
            .clr      (flush),
            .shift_en (shiftEn[c]),
            .din      (din),
            .line_o   (chLine[c]),
            .fill_o   (chFill[c])
        );
    end

    // The snapshot is built from the pre-shift line plus din, i.e. the post-shift contents.
    always_comb begin
        selLine = '0;
        selFill = '0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch == CH_W'(c)) begin
                selLine = chLine[c];
                selFill = chFill[c];
            end
        end
        effLen   = (active_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : active_len;
        postFill = (selFill == LEN_W'(DEPTH)) ? selFill : selFill + 1'b1;
        nextTaps = '0;
        nextTaps[0] = (effLen != '0) ? din : '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (LEN_W'(i) < effLen) begin
                nextTaps[i] = selLine[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValid_q  <= 1'b0;
            outCh_q     <= '0;
            taps_q      <= '0;
            outPrimed_q <= 1'b0;
            errCh_q     <= 1'b0;
        end else if (flush) begin
            outValid_q  <= 1'b0;
            outCh_q     <= '0;
            taps_q      <= '0;
            outPrimed_q <= 1'b0;
            errCh_q     <= 1'b0;
        end else begin
            if (accept && chInRange) begin
                outValid_q  <= 1'b1;
                outCh_q     <= in_ch;
                taps_q      <= nextTaps;
                outPrimed_q <= (postFill >= effLen);
            end else if (popOut) begin
                outValid_q  <= 1'b0;
            end
            if (accept && !chInRange) begin
                errCh_q <= 1'b1;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_ch     = outCh_q;
    assign taps       = taps_q;
    assign out_primed = outPrimed_q;
    assign err_ch     = errCh_q;

endmodule

// File: tb/tb_mc_tapped_delay_line.sv
// Self-checking bench for mc_tapped_delay_line (NCH=3, DEPTH=8) with a reference model and scoreboard.
module tb_mc_tapped_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int NCH   = 3;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b1;
    logic                        flush = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        out_ready = 1'b0;
    logic [1:0]                  in_ch = '0;
    logic [WIDTH-1:0]            din = '0;
    logic [3:0]                  active_len = '0;
    logic                        in_ready;
    logic                        out_valid;
    logic [1:0]                  out_ch;
    logic [DEPTH-1:0][WIDTH-1:0] taps;
    logic                        out_primed;
    logic                        err_ch;

    mc_tapped_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NCH   (NCH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .din        (din),
        .active_len (active_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .taps       (taps),
        .out_primed (out_primed),
        .err_ch     (err_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]                  ch;
        logic [DEPTH-1:0][WIDTH-1:0] taps;
        logic                        primed;
    } snap_t;

    typedef struct {
        logic [1:0]       ch;
        logic [WIDTH-1:0] d;
        logic [3:0]       len;
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        logic             ep;
    } vec_t;

    snap_t                       sbq[$];
    logic [DEPTH-1:0][WIDTH-1:0] mLine [NCH];
    int                          mFill [NCH];
    logic                        mValid = 1'b0;
    logic                        mErr = 1'b0;
    int                          testsRun = 0;
    int                          testsFailed = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int c = 0; c < NCH; c++) begin
            mLine[c] = '0;
            mFill[c] = 0;
        end
        mValid = 1'b0;
        mErr   = 1'b0;
        sbq.delete();
    endtask

    // One clock cycle: drive at negedge, check the pending snapshot, then update the model after the edge.
    task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [WIDTH-1:0] d,
                                 input logic [3:0] len, input logic ordy, input logic fl);
        logic  expReady;
        logic  acc;
        int    effL;
        snap_t s;
        @(negedge clk);
        in_valid   = v;
        in_ch      = ch;
        din        = d;
        active_len = len;
        out_ready  = ordy;
        flush      = fl;
        #1;
        expReady = !fl && (!mValid || ordy);
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("out_valid_pre", out_valid, mValid);
        if (mValid) begin
            if (sbq.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL scoreboard: out_valid expected but no snapshot queued");
            end else begin
                checkOutput("out_ch", out_ch, sbq[0].ch);
                checkOutput("taps", taps, sbq[0].taps);
                checkOutput("out_primed", out_primed, sbq[0].primed);
                if (ordy && !fl) void'(sbq.pop_front());
            end
        end
        @(posedge clk);
        acc = v && expReady;
        if (fl) begin
            clearModel();
        end else begin
            if (mValid && ordy) mValid = 1'b0;
            if (acc) begin
                if (int'(ch) < NCH) begin
                    for (int i = DEPTH - 1; i > 0; i--) mLine[ch][i] = mLine[ch][i-1];
                    mLine[ch][0] = d;
                    if (mFill[ch] < DEPTH) mFill[ch]++;
                    effL = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    s.ch = ch;
                    s.taps = '0;
                    for (int i = 0; i < DEPTH; i++) if (i < effL) s.taps[i] = mLine[ch][i];
                    s.primed = (mFill[ch] >= effL);
                    sbq.push_back(s);
                    mValid = 1'b1;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
        #1;
        checkOutput("out_valid_post", out_valid, mValid);
        checkOutput("err_ch", err_ch, mErr);
        if (fl) begin
            checkOutput("flush_taps", taps, '0);
            checkOutput("flush_out_ch", out_ch, '0);
        end
    endtask

    // Asynchronous reset asserted mid-cycle while a sample is offered.
    task automatic doReset();
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'hBEEF;
        out_ready = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_ch", out_ch, '0);
        checkOutput("rst_taps", taps, '0);
        checkOutput("rst_out_primed", out_primed, 1'b0);
        checkOutput("rst_err_ch", err_ch, 1'b0);
        clearModel();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t                        vecs[6];
        logic [DEPTH-1:0][WIDTH-1:0] e;

        vecs[0] = '{2'd0, 16'd10, 4'd8, 16'd10, 16'd0,  16'd0, 1'b0};
        vecs[1] = '{2'd2, 16'd20, 4'd8, 16'd20, 16'd0,  16'd0, 1'b0};
        vecs[2] = '{2'd0, 16'd11, 4'd8, 16'd11, 16'd10, 16'd0, 1'b0};
        vecs[3] = '{2'd2, 16'd21, 4'd8, 16'd21, 16'd20, 16'd0, 1'b0};
        vecs[4] = '{2'd1, 16'd5,  4'd2, 16'd5,  16'd0,  16'd0, 1'b0};
        vecs[5] = '{2'd1, 16'd6,  4'd2, 16'd6,  16'd5,  16'd0, 1'b1};

        clearModel();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("init_out_valid", out_valid, 1'b0);
        checkOutput("init_taps", taps, '0);
        checkOutput("init_err_ch", err_ch, 1'b0);
        checkOutput("init_out_primed", out_primed, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Interleaved channels from a hand-derived table.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, vecs[k].ch, vecs[k].d, vecs[k].len, 1'b1, 1'b0);
            checkOutput("vec_ch", out_ch, vecs[k].ch);
            checkOutput("vec_tap0", taps[0], vecs[k].e0);
            checkOutput("vec_tap1", taps[1], vecs[k].e1);
            checkOutput("vec_tap2", taps[2], vecs[k].e2);
            checkOutput("vec_primed", out_primed, vecs[k].ep);
        end

        // Back-to-back stream, primed on the 4th sample with active_len=4.
        applyStimulus(1'b0, 2'd0, '0, 4'd8, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 2'd1, WIDTH'(k), 4'd4, 1'b1, 1'b0);
            if (k == 4) checkOutput("s1_primed4", out_primed, 1'b1);
        end
        e = '0;
        e[0] = 16'd5; e[1] = 16'd4; e[2] = 16'd3; e[3] = 16'd2;
        checkOutput("s1_taps", taps, e);

        // Back-pressure: stall for 3 cycles, then pop and accept in the same cycle.
        applyStimulus(1'b1, 2'd0, 16'd100, 4'd8, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'd0, 16'd101, 4'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 16'd200, 4'd8, 1'b1, 1'b0);
        checkOutput("s3_nobubble_valid", out_valid, 1'b1);
        checkOutput("s3_new_tap0", taps[0], 16'd200);

        // Length mask, zero length, and active_len clamped to DEPTH.
        applyStimulus(1'b0, 2'd0, '0, 4'd8, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 2'd0, WIDTH'(k), 4'd3, 1'b1, 1'b0);
        e = '0;
        e[0] = 16'd8; e[1] = 16'd7; e[2] = 16'd6;
        checkOutput("s4_masked", taps, e);
        applyStimulus(1'b1, 2'd0, 16'd9, 4'd0, 1'b1, 1'b0);
        checkOutput("s4_len0", taps, '0);
        applyStimulus(1'b1, 2'd0, 16'd10, 4'd8, 1'b1, 1'b0);
        checkOutput("s4_shift_tap1", taps[1], 16'd9);
        applyStimulus(1'b1, 2'd0, 16'd11, 4'd15, 1'b1, 1'b0);
        checkOutput("s4_clamp_tap7", taps[7], 16'd4);
        checkOutput("s4_clamp_primed", out_primed, 1'b1);

        // Flush during a full stream.
        applyStimulus(1'b1, 2'd2, 16'd77, 4'd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'd2, 16'd9, 4'd8, 1'b1, 1'b0);
        e = '0;
        e[0] = 16'd9;
        checkOutput("s5_after_flush", taps, e);
        checkOutput("s5_primed", out_primed, 1'b0);
        applyStimulus(1'b1, 2'd0, 16'd3, 4'd8, 1'b1, 1'b0);
        checkOutput("s5_ch0_cleared", taps[1], 16'd0);

        // Out-of-range channel is swallowed and sets a sticky error.
        applyStimulus(1'b1, 2'd3, 16'd55, 4'd8, 1'b1, 1'b0);
        checkOutput("s6_err", err_ch, 1'b1);
        checkOutput("s6_no_snapshot", out_valid, 1'b0);
        applyStimulus(1'b1, 2'd1, 16'd56, 4'd8, 1'b1, 1'b0);
        checkOutput("s6_err_sticky", err_ch, 1'b1);
        applyStimulus(1'b0, 2'd0, '0, 4'd8, 1'b1, 1'b1);

        // Async reset mid-burst.
        applyStimulus(1'b1, 2'd2, 16'd31, 4'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 16'd32, 4'd8, 1'b1, 1'b0);
        doReset();
        applyStimulus(1'b1, 2'd2, 16'd40, 4'd8, 1'b1, 1'b0);
        checkOutput("rst_line_cleared", taps[1], 16'd0);

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                          4'($urandom_range(0, 12)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 31) == 0));
        end
        applyStimulus(1'b0, 2'd0, '0, 4'd8, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 4'd8, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
